// File: rtl/seg_display_ctrl.sv
// Multiplexed seven-segment display controller: latches a hex or decimal
// image of a loaded value and scans it across DIGITS active-low digits.
module seg_display_ctrl #(
   parameter int DIGITS      = 4,
   parameter int DATA_W      = 8,
   parameter int REFRESH_DIV = 50000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] value,
   input  logic              load,
   input  logic              mode,
   input  logic              signed_en,
   input  logic              blank_lz,
   output logic              busy,
   output logic              overflow,
   output logic [6:0]        display,
   output logic [DIGITS-1:0] digit_select
);

   localparam int BCD_N = DATA_W / 3 + 1;
   localparam int SRC_N = (BCD_N > DIGITS) ? BCD_N : DIGITS;
   localparam int IW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int PW    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int CW    = $clog2(DATA_W + 1);

   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_MINUS = 7'b0111111;
   localparam logic [6:0] SEG_E     = 7'b0000110;

   if (DIGITS * 4 < DATA_W || DIGITS < 2 || DIGITS > 8 ||
       DATA_W < 4 || DATA_W > 16 || REFRESH_DIV < 2) begin : g_bad_params
      $error("seg_display_ctrl: illegal parameter combination");
   end

   typedef enum logic [1:0] {IDLE, CONVERT, LATCH} state_t;

   state_t                state_q, state_d;
   logic [DATA_W-1:0]     val_q;
   logic [BCD_N*4-1:0]    bcd_q, bcd_adj;
   logic [CW-1:0]         cnt_q;
   logic                  mode_q, neg_q, blank_q;
   logic                  is_neg;
   logic [DATA_W-1:0]     mag;
   logic [SRC_N*4-1:0]    src;
   int                    nd;
   logic                  img_ovf;
   logic [DIGITS*7-1:0]   img, digs_q;
   logic [PW-1:0]         pre_q;
   logic [IW-1:0]         idx_q;
   int                    sel_base;

   function automatic logic [6:0] seg_of(input logic [3:0] n);
      case (n)
         4'h0: seg_of = 7'b1000000;
         4'h1: seg_of = 7'b1111001;
         4'h2: seg_of = 7'b0100100;
         4'h3: seg_of = 7'b0110000;
         4'h4: seg_of = 7'b0011001;
         4'h5: seg_of = 7'b0010010;
         4'h6: seg_of = 7'b0000010;
         4'h7: seg_of = 7'b1111000;
         4'h8: seg_of = 7'b0000000;
         4'h9: seg_of = 7'b0010000;
         4'hA: seg_of = 7'b0001000;
         4'hB: seg_of = 7'b0000011;
         4'hC: seg_of = 7'b1000110;
         4'hD: seg_of = 7'b0100001;
         4'hE: seg_of = 7'b0000110;
         default: seg_of = 7'b0001110;
      endcase
   endfunction

   always_comb begin
      state_d = state_q;
      busy    = 1'b1;
      case (state_q)
         IDLE: begin
            busy = 1'b0;
            if (load) state_d = mode ? CONVERT : LATCH;
         end
         CONVERT: if (cnt_q == CW'(DATA_W - 1)) state_d = LATCH;
         LATCH:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // The most negative input's magnitude (2^(DATA_W-1)) is still exact as an
   // unsigned DATA_W-bit number, so the negation needs no extra storage bit.
   assign is_neg = mode & signed_en & value[DATA_W-1];
   assign mag    = (~value) + DATA_W'(1);

   always_comb begin
      bcd_adj = bcd_q;
      for (int j = 0; j < BCD_N; j++) begin
         if (bcd_q[j*4 +: 4] >= 4'd5) bcd_adj[j*4 +: 4] = bcd_q[j*4 +: 4] + 4'd3;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         val_q   <= '0;
         bcd_q   <= '0;
         cnt_q   <= '0;
         mode_q  <= 1'b0;
         neg_q   <= 1'b0;
         blank_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && load) begin
            mode_q  <= mode;
            neg_q   <= is_neg;
            blank_q <= blank_lz;
            val_q   <= is_neg ? mag : value;
            bcd_q   <= '0;
            cnt_q   <= '0;
         end else if (state_q == CONVERT) begin
            bcd_q <= (bcd_adj << 1) | {{(BCD_N*4-1){1'b0}}, val_q[DATA_W-1]};
            val_q <= val_q << 1;
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   // Image of the converted value; only sampled into digs_q in LATCH.
   always_comb begin
      src = '0;
      if (mode_q) src[BCD_N*4-1:0] = bcd_q;
      else        src[DATA_W-1:0]  = val_q;
      nd = 1;
      for (int i = 0; i < SRC_N; i++) begin
         if (src[i*4 +: 4] != 4'd0) nd = i + 1;
      end
      img_ovf = mode_q && ((nd + (neg_q ? 1 : 0)) > DIGITS);
      img = '1;
      for (int i = 0; i < DIGITS; i++) begin
         if (img_ovf)
            img[i*7 +: 7] = SEG_E;
         else if (i < nd)
            img[i*7 +: 7] = seg_of(src[i*4 +: 4]);
         else if (neg_q && (blank_q ? (i == nd) : (i == DIGITS - 1)))
            img[i*7 +: 7] = SEG_MINUS;
         else if (blank_q)
            img[i*7 +: 7] = SEG_BLANK;
         else
            img[i*7 +: 7] = seg_of(src[i*4 +: 4]);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         digs_q   <= {DIGITS{SEG_BLANK}};
         overflow <= 1'b0;
      end else if (state_q == LATCH) begin
         digs_q   <= img;
         overflow <= img_ovf;
      end
   end

   assign sel_base = int'(idx_q) * 7;

   // Segment and select outputs are both registered from idx_q so they
   // always describe the same digit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pre_q        <= '0;
         idx_q        <= '0;
         display      <= SEG_BLANK;
         digit_select <= ~DIGITS'(1);
      end else begin
         if (pre_q == PW'(REFRESH_DIV - 1)) begin
            pre_q <= '0;
            idx_q <= (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
         end else begin
            pre_q <= pre_q + 1'b1;
         end
         display      <= digs_q[sel_base +: 7];
         digit_select <= ~(DIGITS'(1) << idx_q);
      end
   end

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Bench for seg_display_ctrl: a 4-digit and a 2-digit instance, with an
// arithmetic reference model feeding per-instance expected queues.
module tb_seg_display_ctrl;

   localparam int EXP_W = 65;   // {busy_len[7:0], overflow, image[55:0]}

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] value_v [2];
   logic       load_v  [2];
   logic       mode_v  [2];
   logic       sgn_v   [2];
   logic       blank_v [2];
   logic       busy_v  [2];
   logic       ovf_v   [2];
   logic [6:0] disp_v  [2];
   logic [3:0] sel0;
   logic [1:0] sel1;
   logic [7:0] sel_v   [2];

   int n_checks = 0;
   int n_errors = 0;
   int iss [2];

   logic [6:0] seg_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

   always #5 clk = ~clk;

   seg_display_ctrl #(.DIGITS(4), .DATA_W(8), .REFRESH_DIV(4)) dut0 (
      .clk(clk), .rst(rst), .value(value_v[0]), .load(load_v[0]), .mode(mode_v[0]),
      .signed_en(sgn_v[0]), .blank_lz(blank_v[0]), .busy(busy_v[0]),
      .overflow(ovf_v[0]), .display(disp_v[0]), .digit_select(sel0));

   seg_display_ctrl #(.DIGITS(2), .DATA_W(8), .REFRESH_DIV(4)) dut1 (
      .clk(clk), .rst(rst), .value(value_v[1]), .load(load_v[1]), .mode(mode_v[1]),
      .signed_en(sgn_v[1]), .blank_lz(blank_v[1]), .busy(busy_v[1]),
      .overflow(ovf_v[1]), .display(disp_v[1]), .digit_select(sel1));

   assign sel_v[0] = {4'hF, sel0};
   assign sel_v[1] = {6'h3F, sel1};

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int sel_to_idx(input logic [7:0] s, input int nd);
      int r;
      r = -1;
      for (int j = 0; j < nd; j++) if (s == ~(8'd1 << j)) r = j;
      return r;
   endfunction

   // Reference: what a person would write on the display for this number.
   function automatic logic [EXP_W-1:0] model(input int nd_dig, input logic [7:0] v,
                                              input logic m, input logic s, input logic b);
      int mag, nd, t;
      int dg [8];
      logic neg, ovf;
      logic [55:0] img;
      neg = 1'b0;
      mag = int'(v);
      if (m && s && v[7]) begin
         neg = 1'b1;
         mag = 256 - int'(v);
      end
      t = mag;
      for (int i = 0; i < 8; i++) begin
         dg[i] = m ? t % 10 : t % 16;
         t     = m ? t / 10 : t / 16;
      end
      nd = 1;
      for (int i = 0; i < 8; i++) if (dg[i] != 0) nd = i + 1;
      ovf = m && (nd + int'(neg) > nd_dig);
      img = '1;
      for (int i = 0; i < nd_dig; i++) begin
         if (ovf) img[i*7 +: 7] = 7'b0000110;
         else if (i < nd || !b) img[i*7 +: 7] = seg_tab[dg[i]];
      end
      if (neg && !ovf) img[(b ? nd : nd_dig - 1)*7 +: 7] = 7'b0111111;
      return {8'(m ? 9 : 1), ovf, img};
   endfunction

   for (genvar k = 0; k < 2; k++) begin : g_mon
      localparam int ND = (k == 0) ? 4 : 2;
      logic [EXP_W-1:0] exp_q[$];
      int done_cnt = 0;
      logic [55:0] cur_img = '1;

      initial begin
         int blen, idx;
         logic [EXP_W-1:0] e;
         logic [55:0] seen;
         blen = 0;
         forever begin
            @(negedge clk);
            if (rst) begin
               blen    = 0;
               cur_img = '1;
            end else begin
               idx = sel_to_idx(sel_v[k], ND);
               chk("sel_onehot", 64'(idx >= 0), 64'd1);
               if (busy_v[k]) begin
                  blen++;
                  if (idx >= 0) chk("hold_image", 64'(disp_v[k]), 64'(cur_img[idx*7 +: 7]));
               end else if (blen > 0) begin
                  if (exp_q.size() == 0) begin
                     n_checks++;
                     n_errors++;
                     $display("FAIL unexpected_latch inst %0d: got a latch, required none", k);
                  end else begin
                     e = exp_q.pop_front();
                     chk("busy_len", 64'(blen), 64'(e[64:57]));
                     chk("overflow", 64'(ovf_v[k]), 64'(e[56]));
                     seen = '1;
                     for (int c = 0; c < ND * 4; c++) begin
                        @(negedge clk);
                        idx = sel_to_idx(sel_v[k], ND);
                        if (idx >= 0) seen[idx*7 +: 7] = disp_v[k];
                     end
                     chk("image", 64'(seen[ND*7-1:0]), 64'(e[ND*7-1:0]));
                     cur_img = e[55:0];
                  end
                  blen = 0;
                  done_cnt++;
               end
            end
         end
      end
   end

   task automatic do_load(input int k, input logic [7:0] v, input logic m,
                          input logic s, input logic b);
      logic [EXP_W-1:0] e;
      e = model((k == 0) ? 4 : 2, v, m, s, b);
      if (k == 0) g_mon[0].exp_q.push_back(e);
      else        g_mon[1].exp_q.push_back(e);
      iss[k]++;
      @(negedge clk);
      value_v[k] = v; mode_v[k] = m; sgn_v[k] = s; blank_v[k] = b; load_v[k] = 1'b1;
      @(negedge clk);
      load_v[k] = 1'b0;
   endtask

   task automatic wait_done(input int k);
      int n, d;
      n = 0;
      d = (k == 0) ? g_mon[0].done_cnt : g_mon[1].done_cnt;
      while (d != iss[k] && n < 400) begin
         @(negedge clk);
         n++;
         d = (k == 0) ? g_mon[0].done_cnt : g_mon[1].done_cnt;
      end
      chk("latch_complete", 64'(d), 64'(iss[k]));
   endtask

   initial begin
      logic [3:0] prev, expn;
      int last, nchg;
      logic bad;
      for (int k = 0; k < 2; k++) begin
         value_v[k] = '0; load_v[k] = 0; mode_v[k] = 0; sgn_v[k] = 0; blank_v[k] = 0;
         iss[k] = 0;
      end
      rst = 1'b0;
      #1 rst = 1'b1;
      #1;
      chk("reset_display", 64'(disp_v[0]), 64'h7F);
      chk("reset_select", 64'(sel0), 64'b1110);
      chk("reset_select_2dig", 64'(sel1), 64'b10);
      chk("reset_busy", 64'(busy_v[0]), 64'd0);
      chk("reset_overflow", 64'(ovf_v[0]), 64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      prev = sel0; expn = 4'b1101; last = -1; nchg = 0;
      for (int c = 0; c < 24; c++) begin
         @(negedge clk);
         if (sel0 != prev) begin
            chk("scan_order", 64'(sel0), 64'(expn));
            if (last >= 0) chk("scan_period", 64'(c - last), 64'd4);
            last = c; nchg++; prev = sel0;
            expn = {expn[2:0], expn[3]};
         end
      end
      chk("scan_steps", 64'(nchg >= 4), 64'd1);

      do_load(0, 8'hA5, 0, 0, 0); wait_done(0);
      do_load(0, 8'd255, 1, 0, 1); wait_done(0);
      do_load(0, 8'h80, 1, 1, 1); wait_done(0);
      do_load(0, 8'h00, 1, 1, 1); wait_done(0);
      do_load(0, 8'h80, 1, 1, 0); wait_done(0);
      do_load(0, 8'hFF, 1, 1, 1); wait_done(0);
      do_load(0, 8'hF0, 0, 1, 1); wait_done(0);

      // load while converting is dropped
      do_load(0, 8'd123, 1, 0, 1);
      repeat (2) @(negedge clk);
      value_v[0] = 8'h11; mode_v[0] = 0; load_v[0] = 1;
      @(negedge clk);
      load_v[0] = 0;
      wait_done(0);

      // reset in the middle of a conversion
      @(negedge clk);
      value_v[0] = 8'd77; mode_v[0] = 1; sgn_v[0] = 0; blank_v[0] = 1; load_v[0] = 1;
      @(negedge clk);
      load_v[0] = 0;
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("abort_busy", 64'(busy_v[0]), 64'd0);
      chk("abort_display", 64'(disp_v[0]), 64'h7F);
      chk("abort_overflow", 64'(ovf_v[0]), 64'd0);
      @(negedge clk);
      #2 rst = 1'b0;
      bad = 1'b0;
      repeat (30) begin
         @(negedge clk);
         if (busy_v[0]) bad = 1'b1;
      end
      chk("abort_no_latch", 64'(bad), 64'd0);
      do_load(0, 8'd9, 1, 0, 0); wait_done(0);

      for (int r = 0; r < 30; r++) begin
         do_load(0, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         wait_done(0);
      end

      do_load(1, 8'd200, 1, 0, 1); wait_done(1);
      do_load(1, 8'd42, 1, 0, 1); wait_done(1);
      do_load(1, 8'hFB, 1, 1, 1); wait_done(1);
      do_load(1, 8'hF6, 1, 1, 1); wait_done(1);
      do_load(1, 8'h3C, 0, 1, 0); wait_done(1);
      for (int r = 0; r < 8; r++) begin
         do_load(1, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         wait_done(1);
      end

      chk("queue0_empty", 64'(g_mon[0].exp_q.size()), 64'd0);
      chk("queue1_empty", 64'(g_mon[1].exp_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

endmodule
